// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is
//            defined) feeding a first-word-fall-through byte FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [FIFO_DEPTH_LOG2:0]   count,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int                       c_DEPTH    = 1 << FIFO_DEPTH_LOG2;
    localparam int                       c_CW       = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0]          c_HALF_CNT = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0]          c_BIT_CNT  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] c_FULL_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4,
        S_PARITY    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;
`endif

    state_t                     r_state, w_state_nxt;
    logic                       r_rx_meta, r_rx_sync;
    logic [c_CW-1:0]            r_cnt, w_cnt_nxt;
    logic [2:0]                 r_bit_idx, w_bit_nxt;
    logic [7:0]                 r_shift, w_shift_nxt;
    logic                       r_frame_err, r_overrun;
    logic                       w_tick, w_push, w_ferr, w_par_ok;

    logic [7:0]                 r_mem [c_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;
    logic                       w_pop, w_wr, w_ovr;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit, w_par_nxt;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_par_ok = ~^{r_shift, r_par_bit};
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
`endif
        end else begin
            r_rx_meta   <= rx;
            r_rx_sync   <= r_rx_meta;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par_bit;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_sync) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = c_HALF_CNT;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_cnt_nxt = c_BIT_CNT;
                    w_bit_nxt = '0;
                    w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_cnt_nxt   = c_BIT_CNT;
                    w_bit_nxt   = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_par_nxt   = r_rx_sync;
                    w_cnt_nxt   = c_BIT_CNT;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                if (w_tick) begin
                    if (r_rx_sync && w_par_ok) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (r_rx_sync) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_pop = rd_en && !empty;
    assign w_wr  = w_push && (!full || w_pop);
    assign w_ovr = w_push && full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data   = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL_CNT);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire
